// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring unsigned divider, one quotient bit per clock
module seq_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // Partial remainder. The restoring step keeps it strictly below M, so its
  // top (W+1-th) bit is always zero between steps; only the shifted value
  // that feeds the subtractor needs the extra bit.
  logic [W-1:0]  a;
  logic [W-1:0]  qr;
  logic [W-1:0]  m;
  logic [CW-1:0] cnt;

  logic [W:0]    a_sh;
  logic [W:0]    m_ext;
  logic [W:0]    diff;
  logic [W-1:0]  a_nx;
  logic [W-1:0]  q_nx;
  logic          last;

  assign a_sh  = {a, qr[W-1]};
  assign m_ext = {1'b0, m};
  assign last  = (cnt == CW'(1));

  // Ripple subtractor a_sh - m_ext built from full-adder cells (inverted M, carry-in 1)
  always_comb begin : fac_chain
    logic c;
    logic nb;
    c    = 1'b1;
    nb   = 1'b0;
    diff = '0;
    for (int i = 0; i <= W; i++) begin
      nb      = ~m_ext[i];
      diff[i] = a_sh[i] ^ nb ^ c;
      c       = (a_sh[i] & nb) | (c & (a_sh[i] ^ nb));
    end
  end

  // Negative difference (sign bit set) means restore: keep shifted A, quotient bit 0
  always_comb begin
    a_nx = diff[W] ? a_sh[W-1:0] : diff[W-1:0];
    q_nx = {qr[W-2:0], ~diff[W]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; a zero divisor skips the iteration and retires at once
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = (y != '0) ? S_RUN : S_DONE;
      S_RUN:  if (last)  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Datapath and result registers; results only change on the edge entering DONE
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a           <= '0;
      qr          <= '0;
      m           <= '0;
      cnt         <= '0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (y != '0) begin
              a   <= '0;
              qr  <= x;
              m   <= y;
              cnt <= CW'(W);
            end else begin
              q           <= '1;
              r           <= x;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_RUN: begin
          a   <= a_nx;
          qr  <= q_nx;
          cnt <= cnt - CW'(1);
          if (last) begin
            q           <= q_nx;
            r           <= a_nx;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider (W=8 directed, W=3 exhaustive)
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       start8, start3;
  logic [7:0] x8, y8, q8, r8;
  logic       busy8, done8, dbz8;
  logic [2:0] x3, y3, q3, r3;
  logic       busy3, done3, dbz3;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         cyc;
  } exp_t;

  exp_t sb8[$];
  exp_t sb3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider #(.W(8)) dut8 (
    .clk(clk), .rst_b(rst_b), .start(start8), .x(x8), .y(y8),
    .q(q8), .r(r8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  seq_divider #(.W(3)) dut3 (
    .clk(clk), .rst_b(rst_b), .start(start3), .x(x3), .y(y3),
    .q(q3), .r(r3), .busy(busy3), .done(done3), .div_by_zero(dbz3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare whenever either DUT presents done
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_b === 1'b1) begin
      if (done8 === 1'b1) begin
        if (sb8.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL w8_unexpected_done: got done=1 expected no pending op");
        end else begin
          e = sb8.pop_front();
          check("w8_q", {24'd0, q8}, {24'd0, e.q});
          check("w8_r", {24'd0, r8}, {24'd0, e.r});
          check("w8_dbz", {31'd0, dbz8}, {31'd0, e.dbz});
          check("w8_done_cycle", cyc, e.cyc);
        end
      end
      if (done3 === 1'b1) begin
        if (sb3.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL w3_unexpected_done: got done=1 expected no pending op");
        end else begin
          e = sb3.pop_front();
          check("w3_q", {29'd0, q3}, {24'd0, e.q});
          check("w3_r", {29'd0, r3}, {24'd0, e.r});
          check("w3_dbz", {31'd0, dbz3}, {31'd0, e.dbz});
          check("w3_done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_idle8();
    int n = 0;
    while (busy8 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL w8_idle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic wait_idle3();
    int n = 0;
    while (busy3 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL w3_idle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  // Called at a negedge: start is sampled on the next posedge
  task automatic issue8(input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] qe, input logic [7:0] re, input logic dz);
    x8 = x; y8 = y; start8 = 1'b1;
    sb8.push_back('{qe, re, dz, cyc + 1 + ((y != 0) ? 8 : 0)});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] qe, input logic [7:0] re, input logic dz);
    wait_idle8();
    issue8(x, y, qe, re, dz);
    wait_idle8();
  endtask

  task automatic run3(input logic [2:0] x, input logic [2:0] y);
    logic [7:0] qe, re;
    logic       dz;
    wait_idle3();
    if (y == 0) begin qe = 8'd7; re = {5'd0, x}; dz = 1'b1; end
    else begin qe = {5'd0, x / y}; re = {5'd0, x % y}; dz = 1'b0; end
    x3 = x; y3 = y; start3 = 1'b1;
    sb3.push_back('{qe, re, dz, cyc + 1 + ((y != 0) ? 3 : 0)});
    @(negedge clk);
    start3 = 1'b0;
    wait_idle3();
  endtask

  typedef struct {
    logic [7:0] x, y, q, r;
    logic       dz;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   n;

    vecs[0] = '{8'd7,   8'd100, 8'd0,   8'd7, 1'b0};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0, 1'b0};
    vecs[2] = '{8'd255, 8'd255, 8'd1,   8'd0, 1'b0};
    vecs[3] = '{8'd5,   8'd0,   8'd255, 8'd5, 1'b1};
    vecs[4] = '{8'd9,   8'd3,   8'd3,   8'd0, 1'b0};

    rst_b = 1'b0; start8 = 1'b0; start3 = 1'b0;
    x8 = '0; y8 = '0; x3 = '0; y3 = '0;
    repeat (3) @(negedge clk);
    check("rst_q8", {24'd0, q8}, 32'd0);
    check("rst_r8", {24'd0, r8}, 32'd0);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_dbz8", {31'd0, dbz8}, 32'd0);
    check("rst_q3", {29'd0, q3}, 32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    // 100/7 with busy length
    wait_idle8();
    issue8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    n = 0;
    while (busy8 === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles_100_7", n, 32'd9);

    foreach (vecs[i]) run8(vecs[i].x, vecs[i].y, vecs[i].q, vecs[i].r, vecs[i].dz);

    // start during RUN is ignored; outputs hold previous result (9/3) until DONE
    wait_idle8();
    issue8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    repeat (2) @(negedge clk);
    x8 = 8'd1; y8 = 8'd1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("hold_q_in_run", {24'd0, q8}, 32'd3);
    check("hold_r_in_run", {24'd0, r8}, 32'd0);
    wait_idle8();
    repeat (3) @(negedge clk);
    check("hold_q_in_idle", {24'd0, q8}, 32'd14);
    check("no_extra_op", sb8.size(), 32'd0);

    // start held high: second op accepted in the first IDLE cycle after DONE,
    // operands changed after the first sample take effect only for the second
    issue_held: begin
      x8 = 8'd100; y8 = 8'd7; start8 = 1'b1;
      sb8.push_back('{8'd14, 8'd2, 1'b0, cyc + 9});
      sb8.push_back('{8'd255, 8'd0, 1'b0, cyc + 19});
      @(negedge clk);
      x8 = 8'd255; y8 = 8'd1;
      repeat (10) @(negedge clk);
      start8 = 1'b0;
      wait_idle8();
    end

    // reset mid-operation aborts asynchronously
    issue8(8'd200, 8'd9, 8'd22, 8'd2, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("abort_q8", {24'd0, q8}, 32'd0);
    check("abort_r8", {24'd0, r8}, 32'd0);
    check("abort_busy8", {31'd0, busy8}, 32'd0);
    check("abort_done8", {31'd0, done8}, 32'd0);
    check("abort_dbz8", {31'd0, dbz8}, 32'd0);
    sb8.delete();
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    run8(8'd200, 8'd9, 8'd22, 8'd2, 1'b0);

    // W=3 exhaustive
    for (int xi = 0; xi < 8; xi++)
      for (int yi = 0; yi < 8; yi++)
        run3(3'(xi), 3'(yi));

    repeat (4) @(negedge clk);
    check("sb8_drained", sb8.size(), 32'd0);
    check("sb3_drained", sb3.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
